// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetches one instruction per fetch_req over a simple request/grant/rvalid
//   memory interface, holds it in an instruction register and exposes the
//   RISC-V decode fields as combinational slices of that register.
//   A three-state FSM (IDLE -> REQ -> WAIT -> IDLE) sequences each fetch.
//
// Parameters:
//   RESET_PC   - PC value loaded at reset.
//   NOP_INSTR  - instruction-register value at reset (addi x0,x0,0).
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   fetch_req           - request the next instruction (sampled in IDLE only)
//   pc_write, pc_next   - load a new PC (sampled in IDLE only, wins over fetch)
//   imem_req/imem_addr  - memory request valid / word address
//   imem_gnt            - memory accepted the request
//   imem_rvalid/rdata   - read data valid / read data (used in WAIT only)
//   instr               - instruction register
//   opcode..func7       - decode slices of instr
//   pc                  - PC of the next fetch
//   pc_old              - PC of the instruction held in instr
//   instr_valid         - one-cycle pulse when instr is updated
//   fetch_busy          - high while in REQ or WAIT
//   misalign_fault      - one-cycle misaligned-fetch pulse
//
// Configuration:
//   FETCH_MISALIGN_TRAP_EN - when defined, a fetch_req in IDLE with a
//   misaligned pc raises misalign_fault instead of issuing a request. When
//   undefined, misalign_fault is tied 0 and the low address bits are forced
//   to zero on imem_addr.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  func3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  func7,
    output logic [31:0] pc,
    output logic [31:0] pc_old,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_old_q, pc_old_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;
    logic        pc_misaligned;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pc_old_q      <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_old_q      <= pc_old_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_old_d      = pc_old_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        misalign_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // pc_write wins and swallows a same-cycle fetch_req.
                if (pc_write) begin
                    pc_d = pc_next;
                end else if (fetch_req) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (pc_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    pc_old_d      = pc_q;
                    pc_d          = pc_q + 32'd4;  // wraps mod 2^32
                    instr_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign fetch_busy  = (state_q != S_IDLE);
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_old      = pc_old_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned pc never reaches REQ, so the raw pc is safe to present.
    assign imem_addr      = pc_q;
    assign misalign_fault = misalign_q;
`else
    assign imem_addr      = {pc_q[31:2], 2'b00};
    assign misalign_fault = 1'b0;
`endif

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign func3  = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign func7  = instr_q[31:25];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed self-checking bench for instruction_fetch_unit. Inputs are driven
// 1 time unit after each rising edge and outputs are sampled at the same
// point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_old;
    logic        instr_valid;
    logic        fetch_busy;
    logic        misalign_fault;

    int unsigned n_checks;
    int unsigned n_fail;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .pc_write       (pc_write),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .opcode         (opcode),
        .rd             (rd),
        .func3          (func3),
        .rs1            (rs1),
        .rs2            (rs2),
        .func7          (func7),
        .pc             (pc),
        .pc_old         (pc_old),
        .instr_valid    (instr_valid),
        .fetch_busy     (fetch_busy),
        .misalign_fault (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full zero-wait fetch: fetch_req, gnt in first REQ cycle, rvalid next.
    task automatic do_fetch(input logic [31:0] data);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        imem_gnt  = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        fetch_req   = 1'b0;
        pc_write    = 1'b0;
        pc_next     = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Reset state
        tick();
        tick();
        check("rst_pc",       pc,             32'h0);
        check("rst_pc_old",   pc_old,         32'h0);
        check("rst_instr",    instr,          32'h0000_0013);
        check("rst_opcode",   {25'd0, opcode}, 32'h13);
        check("rst_func3",    {29'd0, func3}, 32'h0);
        check("rst_ivalid",   {31'd0, instr_valid}, 32'h0);
        check("rst_imem_req", {31'd0, imem_req}, 32'h0);
        check("rst_busy",     {31'd0, fetch_busy}, 32'h0);
        check("rst_misalign", {31'd0, misalign_fault}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic fetch, stepped with intermediate checks
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("f1_req",       {31'd0, imem_req}, 32'h1);
        check("f1_addr",      imem_addr,      32'h0);
        check("f1_busy",      {31'd0, fetch_busy}, 32'h1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("f1_wait_req",  {31'd0, imem_req}, 32'h0);
        check("f1_wait_busy", {31'd0, fetch_busy}, 32'h1);
        check("f1_no_ivalid", {31'd0, instr_valid}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("f1_ivalid",    {31'd0, instr_valid}, 32'h1);
        check("f1_instr",     instr,          32'h0050_0093);
        check("f1_opcode",    {25'd0, opcode}, 32'h13);
        check("f1_rd",        {27'd0, rd},    32'h1);
        check("f1_rs1",       {27'd0, rs1},   32'h0);
        check("f1_pc_old",    pc_old,         32'h0);
        check("f1_pc",        pc,             32'h4);
        check("f1_idle_busy", {31'd0, fetch_busy}, 32'h0);
        tick();
        check("f1_pulse_end", {31'd0, instr_valid}, 32'h0);
        check("f1_rd_stable", {27'd0, rd},    32'h1);

        // Grant stall for 5 cycles; rvalid noise during REQ must be ignored
        fetch_req = 1'b1;
        tick();
        fetch_req   = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            check("stall_req",    {31'd0, imem_req}, 32'h1);
            check("stall_addr",   imem_addr,      32'h4);
            check("stall_ivalid", {31'd0, instr_valid}, 32'h0);
            tick();
        end
        imem_rvalid = 1'b0;
        check("stall_instr_kept", instr, 32'h0050_0093);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4020_8033;   // sub x0,x1,x2
        tick();
        imem_rvalid = 1'b0;
        check("r_ivalid",  {31'd0, instr_valid}, 32'h1);
        check("r_opcode",  {25'd0, opcode}, 32'h33);
        check("r_rd",      {27'd0, rd},    32'h0);
        check("r_func3",   {29'd0, func3}, 32'h0);
        check("r_rs1",     {27'd0, rs1},   32'h1);
        check("r_rs2",     {27'd0, rs2},   32'h2);
        check("r_func7",   {25'd0, func7}, 32'h20);
        check("r_pc_old",  pc_old,         32'h4);
        check("r_pc",      pc,             32'h8);

        // rvalid in IDLE is discarded
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("idle_rv_instr",  instr, 32'h4020_8033);
        check("idle_rv_ivalid", {31'd0, instr_valid}, 32'h0);
        check("idle_rv_pc",     pc,    32'h8);

        // pc_write beats same-cycle fetch_req
        pc_write  = 1'b1;
        pc_next   = 32'h0000_0100;
        fetch_req = 1'b1;
        tick();
        pc_write  = 1'b0;
        fetch_req = 1'b0;
        check("pcw_pc",   pc, 32'h100);
        check("pcw_req",  {31'd0, imem_req}, 32'h0);
        check("pcw_busy", {31'd0, fetch_busy}, 32'h0);
        tick();
        check("pcw_req2", {31'd0, imem_req}, 32'h0);

        // Fetch from 0x100; pc_write/fetch_req during WAIT are ignored
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("pcw_addr", imem_addr, 32'h100);
        imem_gnt = 1'b1;
        tick();
        imem_gnt  = 1'b0;
        pc_write  = 1'b1;
        pc_next   = 32'h0000_0200;
        fetch_req = 1'b1;
        tick();
        check("wait_pc_hold", pc, 32'h100);
        check("wait_busy",    {31'd0, fetch_busy}, 32'h1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        pc_write    = 1'b0;
        fetch_req   = 1'b0;
        check("wait_pc",     pc,     32'h104);
        check("wait_pc_old", pc_old, 32'h100);

        // PC wrap at the top of the address space
        pc_write = 1'b1;
        pc_next  = 32'hFFFF_FFFC;
        tick();
        pc_write = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0010_0113;
        tick();
        imem_rvalid = 1'b0;
        check("wrap_pc",     pc,     32'h0);
        check("wrap_pc_old", pc_old, 32'hFFFF_FFFC);

        // Reset asserted in WAIT aborts the fetch; late rvalid is dropped
        pc_write = 1'b1;
        pc_next  = 32'h0000_0040;
        tick();
        pc_write  = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        imem_gnt  = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("abort_in_wait", {31'd0, fetch_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",  {31'd0, fetch_busy}, 32'h0);
        check("abort_pc",    pc,    32'h0);
        check("abort_instr", instr, 32'h0000_0013);
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("late_rv_instr",  instr, 32'h0000_0013);
        check("late_rv_ivalid", {31'd0, instr_valid}, 32'h0);
        check("late_rv_pc",     pc,    32'h0);

        // Misaligned pc
        pc_write = 1'b1;
        pc_next  = 32'h0000_0102;
        tick();
        pc_write  = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault", {31'd0, misalign_fault}, 32'h1);
        check("mis_req",   {31'd0, imem_req}, 32'h0);
        check("mis_busy",  {31'd0, fetch_busy}, 32'h0);
        check("mis_pc",    pc, 32'h102);
        tick();
        check("mis_pulse_end", {31'd0, misalign_fault}, 32'h0);
`else
        check("mis_fault_tied", {31'd0, misalign_fault}, 32'h0);
        check("mis_req",        {31'd0, imem_req}, 32'h1);
        check("mis_addr",       imem_addr, 32'h100);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        check("mis_pc",     pc,     32'h106);
        check("mis_pc_old", pc_old, 32'h102);
`endif

        // Back-to-back fetch via helper after realigning
        pc_write = 1'b1;
        pc_next  = 32'h0000_0010;
        tick();
        pc_write = 1'b0;
        do_fetch(32'h00A5_8593);   // addi x11,x11,10
        check("b2b_ivalid", {31'd0, instr_valid}, 32'h1);
        check("b2b_rd",     {27'd0, rd},  32'd11);
        check("b2b_rs1",    {27'd0, rs1}, 32'd11);
        check("b2b_pc",     pc, 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction-register value at reset (addi x0,x0,0).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- fetch_req, in, 1, control FSM requests the next instruction.
- pc_write, in, 1, load pc_next into PC.
- pc_next, in, 32, new PC (branch/jump target).
- imem_req, out, 1, memory request valid.
- imem_addr, out, 32, memory word address.
- imem_gnt, in, 1, memory accepted the request.
- imem_rvalid, in, 1, read data valid.
- imem_rdata, in, 32, read data.
- instr, out, 32, instruction register.
- opcode, out, 7, instr[6:0].
- rd, out, 5, instr[11:7].
- func3, out, 3, instr[14:12].
- rs1, out, 5, instr[19:15].
- rs2, out, 5, instr[24:20].
- func7, out, 7, instr[31:25].
- pc, out, 32, PC of the next fetch.
- pc_old, out, 32, PC of the instruction held in instr.
- instr_valid, out, 1, one-cycle pulse when instr is updated.
- fetch_busy, out, 1, high in REQ or WAIT.
- misalign_fault, out, 1, misaligned-fetch pulse.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, REQ, WAIT.
REQ-004 In IDLE, fetch_req=1 with pc_write=0 SHALL move the FSM to REQ on the next edge.
REQ-005 In IDLE, pc_write=1 SHALL load pc <= pc_next, take priority over fetch_req, and drop that same-cycle fetch_req.
REQ-006 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; the FSM SHALL hold until imem_gnt=1, then move to WAIT.
REQ-007 imem_rvalid SHALL be ignored outside WAIT.
REQ-008 When imem_rvalid=1 in WAIT, on the same edge the block SHALL perform all of:
- instr <= imem_rdata;
- pc_old <= pc;
- pc <= pc+4, with mod-2^32 wrap (32'hFFFF_FFFC -> 0);
- instr_valid <= 1 for exactly one cycle;
- return to IDLE.
REQ-009 Minimum latency from fetch_req to instr_valid SHALL be 3 cycles (zero-wait gnt, rvalid one cycle after gnt).
REQ-010 fetch_req and pc_write SHALL be ignored while fetch_busy=1.
REQ-011 Decode outputs SHALL be combinational slices of the instr register and stay stable between instr_valid pulses.
REQ-012 imem_req SHALL be 0 in IDLE and WAIT.

Reset
REQ-013 While rst_n=0 the block SHALL hold:
- FSM = IDLE;
- pc = RESET_PC;
- pc_old = RESET_PC;
- instr = NOP_INSTR (opcode 7'b0010011, func3 3'b000);
- instr_valid, imem_req, fetch_busy, misalign_fault = 0.
REQ-014 Reset asserted mid-fetch SHALL abort the transaction; a later imem_rvalid received in IDLE SHALL be discarded.

Configuration
REQ-015 With FETCH_MISALIGN_TRAP_EN defined, fetch_req in IDLE with pc[1:0]!=2'b00 SHALL issue no request, pulse misalign_fault for one cycle, stay in IDLE, and leave pc unchanged.
REQ-016 Without FETCH_MISALIGN_TRAP_EN, misalign_fault SHALL be tied 0 and imem_addr SHALL be {pc[31:2],2'b00}.

Verification
REQ-017 Reset release, fetch_req=1 for one cycle, gnt in the first REQ cycle, rvalid next cycle with rdata=32'h00500093 -> instr_valid pulse; opcode=7'b0010011, rd=1, rs1=0; pc_old=0; pc=4.
REQ-018 Hold imem_gnt=0 for 5 cycles in REQ -> imem_req stays 1 and imem_addr stays constant for all 5 cycles; no instr_valid.
REQ-019 pc_write=1 with pc_next=32'h0000_0100 and fetch_req=1 in the same IDLE cycle -> pc=32'h100; no imem_req; a later fetch uses imem_addr=32'h100.
REQ-020 pc_write=1 during WAIT -> ignored; after rvalid, pc = old pc+4.
REQ-021 pc=32'hFFFF_FFFC, fetch completes -> pc=0, pc_old=32'hFFFF_FFFC.
REQ-022 rst_n pulsed low in WAIT, then rvalid=1 -> instr=32'h00000013, no instr_valid; with FETCH_MISALIGN_TRAP_EN, pc_next=32'h102 then fetch_req -> misalign_fault pulse, imem_req=0.
